// File: rtl/small_mult_scheduler.sv
// Round-robin sharing of one 11x8 signed multiplier among N_REQ tagged requesters.
// Result returns 9 cycles after grant; no result backpressure, grants gated by hold and per-requester caps.

module small_multiplier (
  input  logic        clk,
  input  logic [10:0] a,
  input  logic [7:0]  b,
  output logic [18:0] p
);
  logic signed [18:0] a_ext;
  logic signed [18:0] b_ext;
  logic [18:0]        pipe [9];

  assign a_ext = {{8{a[10]}}, a};
  assign b_ext = {{11{b[7]}}, b};

  always_ff @(posedge clk) begin
    pipe[0] <= a_ext * b_ext;
    for (int k = 1; k < 9; k++) pipe[k] <= pipe[k-1];
  end

  assign p = pipe[8];
endmodule

module small_mult_scheduler #(
  parameter int N_REQ       = 4,
  parameter int MAX_PER_REQ = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [11*N_REQ-1:0]      req_a,
  input  logic [8*N_REQ-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [18:0]              res_product,
  output logic [3:0]               in_flight
);
  localparam int         IDW     = $clog2(N_REQ);
  localparam int         DEPTH   = 9;
  localparam logic [3:0] CNT_MAX = 4'(MAX_PER_REQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t             tags [DEPTH];
  logic [3:0]       cnt  [N_REQ];
  logic [IDW-1:0]   ptr;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] cnt_inc;
  logic [N_REQ-1:0] cnt_dec;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  int               rr_idx;
  logic [10:0]      mul_a;
  logic [7:0]       mul_b;
  logic [18:0]      mul_p;
  logic             retire;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && !hold && rst_n && (cnt[i] < CNT_MAX);
  end

  // Search begins one past the last granted requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = (int'(ptr) + k) % N_REQ;
      if (!grant_vld && eligible[rr_idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(rr_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign mul_a = grant_vld ? req_a[int'(grant_id)*11 +: 11] : '0;
  assign mul_b = grant_vld ? req_b[int'(grant_id)*8 +: 8]   : '0;

  small_multiplier u_mult (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  assign retire      = tags[DEPTH-1].vld;
  assign res_valid   = retire && rst_n;
  assign res_id      = res_valid ? tags[DEPTH-1].id : '0;
  assign res_product = mul_p & {19{res_valid}};

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_inc[i] = grant_vld && (grant_id == IDW'(i));
      cnt_dec[i] = retire && (tags[DEPTH-1].id == IDW'(i));
    end
  end

  // Multiplier data is not reset; cleared tags mask whatever is still inside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) tags[k] <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      ptr       <= IDW'(N_REQ - 1);
      in_flight <= '0;
    end else begin
      tags[0] <= '{vld: grant_vld, id: grant_id};
      for (int k = 1; k < DEPTH; k++) tags[k] <= tags[k-1];
      if (grant_vld) ptr <= grant_id;
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt[i] <= cnt[i] + 4'd1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt[i] <= cnt[i] - 4'd1;
      end
      if (grant_vld && !retire)      in_flight <= in_flight + 4'd1;
      else if (retire && !grant_vld) in_flight <= in_flight - 4'd1;
    end
  end
endmodule

// File: tb/tb_small_mult_scheduler.sv
// Bench for small_mult_scheduler: queue-based reference model plus directed and table-driven sequences.
module tb_small_mult_scheduler;
  localparam int N    = 4;
  localparam int MAXP = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           hold  = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [11*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [18:0]    res_product;
  logic [3:0]     in_flight;

  logic           hold2 = 1'b0;
  logic [N-1:0]   v2 = '0;
  logic [11*N-1:0] a2 = '0;
  logic [8*N-1:0] b2 = '0;
  logic [N-1:0]   rdy2;
  logic           rv2;
  logic [1:0]     rid2;
  logic [18:0]    rp2;
  logic [3:0]     inf2;

  small_mult_scheduler #(.N_REQ(N), .MAX_PER_REQ(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
    .in_flight(in_flight)
  );

  small_mult_scheduler #(.N_REQ(N), .MAX_PER_REQ(2)) dut_cap (
    .clk(clk), .rst_n(rst_n), .hold(hold2), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ready(rdy2), .res_valid(rv2), .res_id(rid2), .res_product(rp2), .in_flight(inf2)
  );

  int tests = 0;
  int fails = 0;
  int t     = 0;

  typedef struct { int cyc; int id; int prod; } ent_t;
  ent_t mq[$];
  ent_t got_q[$];
  int   ptr_m = N - 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, t);
    end
  endtask

  // Reference model: a product is in flight from the cycle after its grant
  // through the cycle its result is presented (grant cycle + 9).
  always @(negedge clk) begin : model_blk
    int exp_v, exp_id, exp_p, total, g, idx;
    int cnt_m[N];
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_res_id", int'(res_id), 0);
      check("rst_res_product", int'(res_product), 0);
      mq.delete();
      ptr_m = N - 1;
    end else begin
      exp_v = 0; exp_id = 0; exp_p = 0; total = 0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
      foreach (mq[k]) begin
        if (mq[k].cyc + 9 == t) begin
          exp_v = 1; exp_id = mq[k].id; exp_p = mq[k].prod;
        end
        cnt_m[mq[k].id]++;
        total++;
      end
      check("res_valid", int'(res_valid), exp_v);
      check("res_product", int'($signed(res_product)), exp_p);
      if (exp_v != 0) check("res_id", int'(res_id), exp_id);
      check("in_flight", int'(in_flight), total);
      if (res_valid) got_q.push_back('{t, int'(res_id), int'($signed(res_product))});
      exp_rdy = '0;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && req_valid[idx] && !hold && cnt_m[idx] < MAXP) g = idx;
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        mq.push_back('{t, g, int'($signed(req_a[g*11 +: 11])) * int'($signed(req_b[g*8 +: 8]))});
        ptr_m = g;
      end
      check("req_ready", int'(req_ready), int'(exp_rdy));
      while (mq.size() > 0 && mq[0].cyc + 9 <= t) void'(mq.pop_front());
    end
    t++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_a = '0; req_b = '0; hold = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) next_cycle();
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct { int a; int b; int prod; } vec_t;
  vec_t vecs[16];
  int   tab_a[4] = '{1023, -1024, 0, -1};
  int   tab_b[4] = '{127, -128, 1, -1};
  int   tab_p[16] = '{129921, -130944, 1023, -1023,
                      -130048, 131072, -1024, 1024,
                      0, 0, 0, 0,
                      -127, 128, -1, 1};

  int t0, t_iss, c2, r2, grants2, gap_hits;
  int issues2[$];

  initial begin
    for (int k = 0; k < 16; k++) vecs[k] = '{tab_a[k/4], tab_b[k%4], tab_p[k]};

    next_cycle();
    reset_dut();

    // Single issue with the largest positive product
    got_q.delete();
    req_valid = 4'b0100;
    req_a[22 +: 11] = 11'h400;
    req_b[16 +: 8]  = 8'h80;
    t_iss = t;
    @(negedge clk);
    check("single_ready", int'(req_ready), 4);
    next_cycle();
    idle(12);
    check("single_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("single_id", got_q[0].id, 2);
      check("single_product", got_q[0].prod, 131072);
      check("single_latency", got_q[0].cyc - t_iss, 9);
    end

    // Round-robin with all requesters continuously valid
    reset_dut();
    got_q.delete();
    for (int i = 0; i < N; i++) begin
      req_a[i*11 +: 11] = 11'(i + 1);
      req_b[i*8 +: 8]   = 8'd3;
    end
    req_valid = '1;
    t0 = t;
    repeat (12) next_cycle();
    idle(12);
    check("rr_count", got_q.size(), 12);
    foreach (got_q[j]) begin
      check("rr_id", got_q[j].id, j % 4);
      check("rr_product", got_q[j].prod, 3 * (j % 4 + 1));
      check("rr_cycle", got_q[j].cyc - t0, 9 + j);
    end

    // Hold during cycles 3..6 of a continuous stream
    reset_dut();
    got_q.delete();
    t0 = t;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*11 +: 11] = 11'(i + 1);
        req_b[i*8 +: 8]   = 8'd3;
      end
      req_valid = '1;
      hold = (k >= 3 && k <= 6);
      next_cycle();
    end
    idle(12);
    check("hold_count", got_q.size(), 16);
    gap_hits = 0;
    foreach (got_q[j]) begin
      if (got_q[j].cyc - t0 >= 12 && got_q[j].cyc - t0 <= 15) gap_hits++;
      check("hold_cycle", got_q[j].cyc - t0, (j < 3) ? 9 + j : 13 + j);
      check("hold_id", got_q[j].id, j % 4);
    end
    check("hold_gap", gap_hits, 0);

    // Reset while products are in flight
    reset_dut();
    got_q.delete();
    req_valid = 4'b0001;
    req_a[0 +: 11] = 11'd100;
    req_b[0 +: 8]  = 8'd2;
    repeat (5) next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_flight", int'(in_flight), 0);
    idle(14);
    check("post_rst_stale", got_q.size(), 0);
    req_valid = 4'b0001;
    req_a[0 +: 11] = 11'd7;
    req_b[0 +: 8]  = 8'hFB;
    t_iss = t;
    next_cycle();
    idle(11);
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("post_rst_product", got_q[0].prod, -35);
      check("post_rst_latency", got_q[0].cyc - t_iss, 9);
    end

    // Sign corners, back-to-back over rotating requesters
    reset_dut();
    got_q.delete();
    t0 = t;
    for (int k = 0; k < 16; k++) begin
      clear_inputs();
      req_valid[k % 4] = 1'b1;
      req_a[(k % 4)*11 +: 11] = 11'(vecs[k].a);
      req_b[(k % 4)*8 +: 8]   = 8'(vecs[k].b);
      next_cycle();
    end
    idle(11);
    check("corner_count", got_q.size(), 16);
    foreach (got_q[j]) begin
      if (j < 16) begin
        check("corner_product", got_q[j].prod, vecs[j].prod);
        check("corner_id", got_q[j].id, j % 4);
        check("corner_cycle", got_q[j].cyc - t0, 9 + j);
      end
    end

    // Per-requester cap of 2 with only requester 1 asking
    reset_dut();
    issues2.delete();
    grants2 = 0;
    v2 = 4'b0010;
    a2[11 +: 11] = 11'd5;
    b2[8 +: 8]   = 8'd6;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      c2 = 0; r2 = 0;
      foreach (issues2[j]) begin
        if (issues2[j] < k && k <= issues2[j] + 9) c2++;
        if (issues2[j] + 9 == k) r2 = 1;
      end
      check("cap_ready", int'(rdy2), (c2 < 2) ? 2 : 0);
      check("cap_in_flight", int'(inf2), c2);
      check("cap_res_valid", int'(rv2), r2);
      check("cap_res_product", int'($signed(rp2)), (r2 != 0) ? 30 : 0);
      if (r2 != 0) check("cap_res_id", int'(rid2), 1);
      if (rdy2 != '0) grants2++;
      if (c2 < 2) issues2.push_back(k);
      next_cycle();
    end
    v2 = '0;
    check("cap_grants", grants2, 8);

    // Randomized traffic, including a single-requester run to reach the cap of 9
    reset_dut();
    for (int k = 0; k < 500; k++) begin
      req_valid = 4'($urandom);
      hold  = ($urandom_range(0, 9) == 0);
      req_a = 44'({$urandom, $urandom});
      req_b = 32'($urandom);
      next_cycle();
    end
    for (int k = 0; k < 30; k++) begin
      req_valid = 4'b1000;
      hold  = 1'b0;
      req_a = 44'({$urandom, $urandom});
      req_b = 32'($urandom);
      next_cycle();
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
